// File: rtl/qsn_pkg.sv
// Shared definitions for the QSN pipelined cyclic shifter: direction encoding,
// network widths, latency and the effective-shift helper.
package qsn_pkg;

  typedef enum logic {
    QSN_FWD = 1'b0,
    QSN_INV = 1'b1
  } qsn_dir_e;

  // Wide enough for any legal shift of a lifting size up to 511.
  localparam int QSN_EW = 9;

  // Register stages that are always present: input capture and rotation.
  localparam int QSN_BASE_LATENCY = 2;

  function automatic int qsn_left_w(input int z);
    return z - 1;
  endfunction

  function automatic int qsn_right_w(input int z);
    return z;
  endfunction

  function automatic int qsn_merge_w(input int z);
    return z - 1;
  endfunction

  function automatic int qsn_latency(input int extra_stages);
    return QSN_BASE_LATENCY + extra_stages;
  endfunction

  // Only meaningful for a legal shift (< z); an inverse shift of 0 stays 0.
  function automatic logic [QSN_EW-1:0] qsn_effective_shift(
    input logic [QSN_EW-1:0] shift,
    input logic              dir,
    input int                z
  );
    logic [QSN_EW-1:0] z_w;
    z_w = QSN_EW'(z);
    if (dir == QSN_INV && shift != '0) return z_w - shift;
    return shift;
  endfunction

endpackage

// File: rtl/qsn_pipe_shifter_rot_core.sv
// Single-plane QSN rotation: out[j] = in[(j + shift) mod Z], built from a left
// network, a right network and a per-bit merge, all decoded from the shift.
module qsn_rot_core
  import qsn_pkg::*;
#(
  parameter int Z  = 85,
  parameter int SW = 7
) (
  input  logic [Z-1:0]  din,
  input  logic [SW-1:0] shift,
  output logic [Z-1:0]  dout
);

  localparam int LW = qsn_left_w(Z);
  localparam int RW = qsn_right_w(Z);
  localparam int MW = qsn_merge_w(Z);
  localparam logic [SW:0] Z_EXT = (SW+1)'(Z);

  logic [SW-1:0] left_sel;
  logic [SW:0]   right_sel;
  logic [MW-1:0] merge_sel;
  logic [LW-1:0] left_net;
  logic [RW-1:0] right_net;

  // Bit j takes the left network while j + shift stays below Z; the top bit is
  // always supplied by the right network, which passes data through at shift 0.
  always_comb begin
    left_sel  = shift;
    right_sel = (shift == '0) ? '0 : Z_EXT - {1'b0, shift};
    merge_sel = '0;
    for (int j = 0; j < MW; j++) begin
      merge_sel[j] = ({1'b0, shift} <= (SW+1)'(Z - 1 - j));
    end
  end

  assign left_net  = LW'(din >> left_sel);
  assign right_net = din << right_sel;

  always_comb begin
    dout = right_net;
    for (int j = 0; j < MW; j++) begin
      dout[j] = merge_sel[j] ? left_net[j] : right_net[j];
    end
  end

endmodule

// File: rtl/qsn_pipe_shifter.sv
// Elastic valid/ready pipeline around Q QSN rotation cores, with illegal-shift
// flagging and a saturating error counter.
module qsn_pipe_shifter
  import qsn_pkg::*;
#(
  parameter int Z            = 85,
  parameter int Q            = 4,
  parameter int SW           = 7,
  parameter int EXTRA_STAGES = 0,
  parameter int ERRW         = 16
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [Q*Z-1:0]  in_data,
  input  logic [SW-1:0]   in_shift,
  input  logic            in_dir,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Q*Z-1:0]  out_data,
  output logic            out_err,
  output logic [ERRW-1:0] err_count
);

  localparam int LATENCY = qsn_latency(EXTRA_STAGES);
  localparam int QZ      = Q * Z;
  localparam logic [SW:0] Z_EXT = (SW+1)'(Z);

  logic              illegal;
  logic [SW-1:0]     e_in;
  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] load;
  logic [LATENCY-1:0] err_q;
  logic [QZ-1:0]     data_q [LATENCY];
  logic [SW-1:0]     e_q;
  logic [QZ-1:0]     rot_data;

  assign illegal = ({1'b0, in_shift} >= Z_EXT);
  assign e_in    = illegal ? '0
                 : SW'(qsn_effective_shift(QSN_EW'(in_shift), in_dir, Z));

  // Stage k may load when it or any later stage is empty, or the sink drains;
  // this is the unrolled form of the per-stage ready chain.
  for (genvar k = 0; k < LATENCY; k++) begin : g_load
    assign load[k] = out_ready | ~(&valid_q[LATENCY-1:k]);
  end

  for (genvar p = 0; p < Q; p++) begin : g_rot
    qsn_rot_core #(.Z(Z), .SW(SW)) u_rot (
      .din   (data_q[0][p*Z +: Z]),
      .shift (e_q),
      .dout  (rot_data[p*Z +: Z])
    );
  end

  // NOTE: the data registers are reset as well, because out_data must read
  // zero after reset rather than whatever the flops powered up with.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      err_q     <= '0;
      e_q       <= '0;
      err_count <= '0;
      for (int k = 0; k < LATENCY; k++) data_q[k] <= '0;
    end else begin
      if (load[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= illegal ? '0 : in_data;
          err_q[0]  <= illegal;
          e_q       <= e_in;
        end
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            data_q[k] <= (k == 1) ? rot_data : data_q[k-1];
            err_q[k]  <= err_q[k-1];
          end
        end
      end
      if (in_valid && load[0] && illegal && err_count != '1) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];

endmodule
